pipelined_csel_adder: RTL and testbench

- Parametrised, pipelined carry-select adder/subtractor. Next generation of the team's N-bit ripple-carry adder and the 32-bit carry-select adder.
- The operand is split into SEG-bit segments. Each segment is one pipeline stage, with registered carry hand-off between stages and a valid/ready handshake on both sides.
- Used in the datapath wherever a full-width add/sub at high clock rate is needed and multi-cycle latency is acceptable.

---
 rtl/pipelined_csel_adder.sv | 139 +++++++++++++
 tb/tb_pipelined_csel_adder.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_csel_adder.sv
// pipelined_csel_adder: N-bit add/sub built from SEG-bit carry-select stages.
// Ports: clk, rst (async, active-high); in_valid/in_ready, input1, input2,
//   cin, sub in; out_valid/out_ready, result, cout out.
//   Macro CSEL_OVF_EN adds output ovf (signed overflow, pipelined with result).
module pipelined_csel_adder #(
  parameter int N   = 32,
  parameter int SEG = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] input1,
  input  logic [N-1:0] input2,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
`ifdef CSEL_OVF_EN
  output logic         cout,
  output logic         ovf
`else
  output logic         cout
`endif
);

  localparam int SEGC = (SEG < 1) ? 1 : SEG;
  localparam int L    = (N / SEGC < 1) ? 1 : N / SEGC;

  if ((SEG < 1) || ((N % SEGC) != 0)) begin : g_bad_cfg
    $error("pipelined_csel_adder: need SEG >= 1 and N %% SEG == 0");
  end

  logic         en;

  logic         v_q  [L];
  logic         c_q  [L];
  logic [N-1:0] s_q  [L];
  logic [N-1:0] a_q  [L];
  logic [N-1:0] b_q  [L];

  // Stage inputs: operands, carry, partial result and valid entering stage k
  logic         v_x  [L];
  logic         ci_x [L];
  logic [N-1:0] s_x  [L];
  logic [N-1:0] a_x  [L];
  logic [N-1:0] b_x  [L];

  logic         c_d  [L];
  logic [N-1:0] s_d  [L];

`ifdef CSEL_OVF_EN
  logic         ovf_d;
  logic         ovf_q;
`endif

  // Whole pipe moves together; a full output slot blocks everything.
  assign en       = ~v_q[L-1] | out_ready;
  assign in_ready = en;

  for (genvar k = 0; k < L; k++) begin : g_stg
    logic [SEG-1:0] a_seg;
    logic [SEG-1:0] b_seg;
    logic [SEG-1:0] sum;
    logic [SEG:0]   r0;
    logic [SEG:0]   r1;
    logic           co;

    if (k == 0) begin : g_in
      assign v_x[0]  = in_valid;
      assign a_x[0]  = input1;
      assign b_x[0]  = sub ? ~input2 : input2;
      assign ci_x[0] = sub | cin;
      assign s_x[0]  = '0;
    end else begin : g_in
      assign v_x[k]  = v_q[k-1];
      assign a_x[k]  = a_q[k-1];
      assign b_x[k]  = b_q[k-1];
      assign ci_x[k] = c_q[k-1];
      assign s_x[k]  = s_q[k-1];
    end

    assign a_seg = a_x[k][k*SEG +: SEG];
    assign b_seg = b_x[k][k*SEG +: SEG];

    // Both carry hypotheses, picked by the carry handed in
    assign r0 = {1'b0, a_seg} + {1'b0, b_seg};
    assign r1 = r0 + (SEG+1)'(1);
    assign {co, sum} = ci_x[k] ? r1 : r0;

    assign c_d[k] = co;
    assign s_d[k] = s_x[k] | (N'(sum) << (k*SEG));

`ifdef CSEL_OVF_EN
    if (k == L-1) begin : g_ovf
      // MSB sum bit exposes the carry into the MSB
      assign ovf_d = a_seg[SEG-1] ^ b_seg[SEG-1] ^ sum[SEG-1] ^ co;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < L; k++) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        s_q[k] <= '0;
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
    end else if (en) begin
      for (int k = 0; k < L; k++) begin
        v_q[k] <= v_x[k];
        c_q[k] <= c_d[k];
        s_q[k] <= s_d[k];
        a_q[k] <= a_x[k];
        b_q[k] <= b_x[k];
      end
    end
  end

`ifdef CSEL_OVF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (en) begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  assign out_valid = v_q[L-1];
  assign result    = s_q[L-1];
  assign cout      = c_q[L-1];

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// tb_pipelined_csel_adder: random + directed scoreboard bench.
// Reference model uses plain wide arithmetic on whole operands.
module tb_pipelined_csel_adder;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] input1 = '0;
  logic [N-1:0] input2 = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [N-1:0] result;
  logic         cout;
`ifdef CSEL_OVF_EN
  logic         ovf;
`endif

  typedef struct {
    logic [31:0] r;
    logic        c;
    logic        o;
  } exp_t;

  exp_t        scb[$];
  int          tests = 0;
  int          fails = 0;
  int          rdy_mode = 0;
  int          hold_cnt = 0;
  int          stalls = 0;
  logic        pend = 1'b0;
  logic [31:0] pr = '0;
  logic        pc = 1'b0;

  pipelined_csel_adder #(.N(N), .SEG(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .input1    (input1),
    .input2    (input2),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
`ifdef CSEL_OVF_EN
    .cout      (cout),
    .ovf       (ovf)
`else
    .cout      (cout)
`endif
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic ci, input logic s);
    exp_t            e;
    longint          sa;
    longint          sbv;
    longint          v;
    longint unsigned full;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    if (s) begin
      e.r = a - b;
      e.c = (a >= b);
      v   = sa - sbv;
    end else begin
      full = 64'(a) + 64'(b) + 64'(ci);
      e.r  = full[31:0];
      e.c  = full[32];
      v    = sa + sbv + longint'(ci);
    end
    e.o = (v > 64'sd2147483647) || (v < -64'sd2147483648);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic ci, input logic s);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    input1   = a;
    input2   = b;
    cin      = ci;
    sub      = s;
    #2;
    n = 0;
    while (!in_ready && n < 200) begin
      n++;
      stalls++;
      @(negedge clk);
      #2;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready=0 after %0d cycles, want 1", n);
    end else begin
      scb.push_back(model(a, b, ci, s));
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (scb.size() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (scb.size() > 0) begin
      fails++;
      $display("FAIL drain: %0d beats still pending, want 0", scb.size());
    end
  endtask

  // Downstream ready generator
  initial begin
    forever begin
      @(negedge clk);
      if (rdy_mode == 0) out_ready = 1'b1;
      else if (rdy_mode == 2) out_ready = 1'b0;
      else if (hold_cnt > 0) begin
        out_ready = 1'b0;
        hold_cnt--;
      end else out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: handshake rule, hold stability, in-order scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        pend = 1'b0;
      end else begin
        tests++;
        if (in_ready !== (!out_valid || out_ready)) begin
          fails++;
          $display("FAIL in_ready: got %b want %b", in_ready,
                   (!out_valid || out_ready));
        end
        if (pend) begin
          tests++;
          if (out_valid !== 1'b1 || result !== pr || cout !== pc) begin
            fails++;
            $display("FAIL hold: got v=%b r=%h c=%b want v=1 r=%h c=%b",
                     out_valid, result, cout, pr, pc);
          end
        end
        if (out_valid === 1'b1 && out_ready) begin
          tests++;
          if (scb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_beat: got r=%h want none", result);
          end else begin
            e = scb.pop_front();
`ifdef CSEL_OVF_EN
            if (result !== e.r || cout !== e.c || ovf !== e.o) begin
              fails++;
              $display("FAIL result: got r=%h c=%b o=%b want r=%h c=%b o=%b",
                       result, cout, ovf, e.r, e.c, e.o);
            end
`else
            if (result !== e.r || cout !== e.c) begin
              fails++;
              $display("FAIL result: got r=%h c=%b want r=%h c=%b",
                       result, cout, e.r, e.c);
            end
`endif
          end
        end
        pend = out_valid && !out_ready;
        pr   = result;
        pc   = cout;
      end
    end
  end

  initial begin
    int lat;
    int cnt;
    repeat (3) @(negedge clk);
    #2;
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Latency and full carry ripple
    rdy_mode = 0;
    send(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      #2;
      lat++;
    end
    chk("latency", 32'(lat), 32'd4);
    drain();

    // Subtract, cin ignored on sub
    send(32'd5, 32'd7, 1'b0, 1'b1);
    send(32'd7, 32'd5, 1'b0, 1'b1);
    send(32'd7, 32'd5, 1'b1, 1'b1);
    send(32'h0, 32'h0, 1'b1, 1'b1);
    idle();
    drain();

    // Back-to-back throughput
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      send($urandom, $urandom, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
    end
    idle();
    chk("throughput_stalls", 32'(stalls), 32'd0);
    drain();

    // Backpressure with a forced 6-cycle hold
    rdy_mode = 1;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) hold_cnt = 6;
      if ($urandom_range(0, 3) == 0) idle();
      send($urandom, $urandom, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
    end
    idle();
    rdy_mode = 0;
    drain();

`ifdef CSEL_OVF_EN
    send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    send(32'h8000_0000, 32'h1, 1'b0, 1'b1);
    send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    idle();
    drain();
`endif

    // Reset with beats in flight and the output stalled
    rdy_mode = 2;
    send($urandom, $urandom, 1'b0, 1'b0);
    send($urandom, $urandom, 1'b1, 1'b0);
    send($urandom, $urandom, 1'b0, 1'b1);
    idle();
    repeat (3) @(negedge clk);
    #2;
    chk("stalled_valid", 32'(out_valid), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_cout", 32'(cout), 32'd0);
    scb.delete();
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #2;
      if (out_valid) cnt++;
    end
    chk("stale_after_rst", 32'(cnt), 32'd0);

    send(32'd1, 32'd2, 1'b0, 1'b0);
    idle();
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
